// File: rtl/tron_arena_n.sv
// tron_arena_n: N-bike light-cycle arena. Bikes advance one STEP every
// FRAMES_PER_MOVE frame ticks; a bike dies on a wall hit or a head-on /
// swap collision with another live bike. A round ends when at most one
// bike is left alive.
//
// Ports (N = NUM_BIKES, W = COORD_W, bike i uses slice i of every vector):
//   Clk, Reset            clock, synchronous active-high reset
//   frame_clk             ~60 Hz frame strobe, edge-detected internally
//   start                 load spawns and begin a round (ignored in RUN)
//   spawn_x/y, spawn_dir  spawn positions/directions, sampled on start
//   dir_req, dir_req_valid  per-bike steering requests
//   bike_x/y, bike_dir    current positions and directions
//   alive                 per-bike alive flags
//   state                 0 IDLE, 1 RUN, 2 OVER
//   move_tick             high in the cycle whose closing edge applies moves
//   winner_valid/id       single survivor report in OVER
module tron_arena_n #(
  parameter int unsigned NUM_BIKES       = 2,
  parameter int unsigned COORD_W         = 10,
  parameter int unsigned X_MIN           = 14,
  parameter int unsigned X_MAX           = 462,
  parameter int unsigned Y_MIN           = 14,
  parameter int unsigned Y_MAX           = 462,
  parameter int unsigned STEP            = 1,
  parameter int unsigned FRAMES_PER_MOVE = 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_clk,
  input  logic                           start,
  input  logic [NUM_BIKES*COORD_W-1:0]   spawn_x,
  input  logic [NUM_BIKES*COORD_W-1:0]   spawn_y,
  input  logic [2*NUM_BIKES-1:0]         spawn_dir,
  input  logic [2*NUM_BIKES-1:0]         dir_req,
  input  logic [NUM_BIKES-1:0]           dir_req_valid,
  output logic [NUM_BIKES*COORD_W-1:0]   bike_x,
  output logic [NUM_BIKES*COORD_W-1:0]   bike_y,
  output logic [2*NUM_BIKES-1:0]         bike_dir,
  output logic [NUM_BIKES-1:0]           alive,
  output logic [1:0]                     state,
  output logic                           move_tick,
  output logic                           winner_valid,
  output logic [2:0]                     winner_id
);

  localparam int unsigned N     = NUM_BIKES;
  localparam int unsigned W     = COORD_W;
  localparam int unsigned W1    = COORD_W + 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [W-1:0]     STEP_W   = W'(STEP);
  localparam logic [W1-1:0]    STEP_W1  = W1'(STEP);
  localparam logic [W-1:0]     X_LO     = W'(X_MIN + STEP);
  localparam logic [W-1:0]     Y_LO     = W'(Y_MIN + STEP);
  localparam logic [W1-1:0]    X_HI     = W1'(X_MAX);
  localparam logic [W1-1:0]    Y_HI     = W1'(Y_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_MOVE - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               frame_q, frame_d;
  logic               tick_q, tick_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       x_q [N];
  logic [W-1:0]       x_d [N];
  logic [W-1:0]       y_q [N];
  logic [W-1:0]       y_d [N];
  logic [1:0]         dir_q [N];
  logic [1:0]         dir_d [N];
  logic [1:0]         pend_q [N];
  logic [1:0]         pend_d [N];
  logic [N-1:0]       alive_q, alive_d;
  logic               win_v_q, win_v_d;
  logic [2:0]         win_id_q, win_id_d;

  // Per-move combinational results
  logic [1:0]         sel_dir [N];
  logic [W-1:0]       nx [N];
  logic [W-1:0]       ny [N];
  logic [N-1:0]       wall;
  logic [N-1:0]       part;
  logic [N-1:0]       hit;
  logic [N-1:0]       die;
  logic [N-1:0]       alive_after;
  int unsigned        n_alive;
  logic [2:0]         surv_id;

  // A move happens only on the tick that wraps the frame counter in RUN
  assign move_tick = tick_q && (state_q == S_RUN) && (cnt_q == CNT_LAST);

  // Direction selection, wall checks and candidate next positions
  always_comb begin
    wall = '0;
    for (int i = 0; i < N; i++) begin
      // Reverse of a direction differs only in bit 0 (up/down, left/right)
      sel_dir[i] = (pend_q[i] == (dir_q[i] ^ 2'b01)) ? dir_q[i] : pend_q[i];
      nx[i] = x_q[i];
      ny[i] = y_q[i];
      case (sel_dir[i])
        DIR_UP: begin
          if (y_q[i] < Y_LO) wall[i] = 1'b1;
          else               ny[i]   = y_q[i] - STEP_W;
        end
        DIR_DOWN: begin
          if (({1'b0, y_q[i]} + STEP_W1) > Y_HI) wall[i] = 1'b1;
          else                                   ny[i]   = y_q[i] + STEP_W;
        end
        DIR_LEFT: begin
          if (x_q[i] < X_LO) wall[i] = 1'b1;
          else               nx[i]   = x_q[i] - STEP_W;
        end
        default: begin
          if (({1'b0, x_q[i]} + STEP_W1) > X_HI) wall[i] = 1'b1;
          else                                   nx[i]   = x_q[i] + STEP_W;
        end
      endcase
    end
  end

  // Head-on and swap collisions among live bikes that are not hitting a wall
  always_comb begin
    part = alive_q & ~wall;
    hit  = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if ((i != j) && part[i] && part[j]) begin
          if ((nx[i] == nx[j]) && (ny[i] == ny[j]))
            hit[i] = 1'b1;
          if ((nx[i] == x_q[j]) && (ny[i] == y_q[j]) &&
              (nx[j] == x_q[i]) && (ny[j] == y_q[i]))
            hit[i] = 1'b1;
        end
      end
    end
    die         = alive_q & (wall | hit);
    alive_after = alive_q & ~die;
  end

  // Survivor count and index of the (last) survivor
  always_comb begin
    n_alive = 0;
    surv_id = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (alive_after[i]) begin
        n_alive = n_alive + 1;
        surv_id = 3'(i);
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_clk;
    tick_d   = frame_clk & ~frame_q;
    cnt_d    = cnt_q;
    alive_d  = alive_q;
    win_v_d  = win_v_q;
    win_id_d = win_id_q;
    for (int i = 0; i < N; i++) begin
      x_d[i]    = x_q[i];
      y_d[i]    = y_q[i];
      dir_d[i]  = dir_q[i];
      pend_d[i] = dir_req_valid[i] ? dir_req[2*i +: 2] : pend_q[i];
    end

    case (state_q)
      S_RUN: begin
        if (tick_q)
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        if (move_tick) begin
          for (int i = 0; i < N; i++) begin
            dir_d[i]  = alive_q[i] ? sel_dir[i] : dir_q[i];
            pend_d[i] = alive_q[i] ? sel_dir[i] : dir_q[i];
            if (alive_after[i]) begin
              x_d[i] = nx[i];
              y_d[i] = ny[i];
            end
          end
          alive_d = alive_after;
          if (n_alive <= 1) begin
            state_d  = S_OVER;
            win_v_d  = (n_alive == 1);
            win_id_d = (n_alive == 1) ? surv_id : 3'd0;
          end
        end
      end
      default: begin
        // IDLE and OVER: counter parked, ticks ignored, start accepted
        cnt_d = '0;
        if (start) begin
          state_d  = S_RUN;
          alive_d  = '1;
          win_v_d  = 1'b0;
          win_id_d = 3'd0;
          for (int i = 0; i < N; i++) begin
            x_d[i]    = spawn_x[i*W +: W];
            y_d[i]    = spawn_y[i*W +: W];
            dir_d[i]  = spawn_dir[2*i +: 2];
            pend_d[i] = spawn_dir[2*i +: 2];
          end
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      frame_q  <= 1'b0;
      tick_q   <= 1'b0;
      cnt_q    <= '0;
      alive_q  <= '0;
      win_v_q  <= 1'b0;
      win_id_q <= 3'd0;
      for (int i = 0; i < N; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        dir_q[i]  <= 2'd0;
        pend_q[i] <= 2'd0;
      end
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
      alive_q  <= alive_d;
      win_v_q  <= win_v_d;
      win_id_q <= win_id_d;
      for (int i = 0; i < N; i++) begin
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        dir_q[i]  <= dir_d[i];
        pend_q[i] <= pend_d[i];
      end
    end
  end

  // Pack per-bike registers onto the output vectors
  always_comb begin
    bike_x   = '0;
    bike_y   = '0;
    bike_dir = '0;
    for (int i = 0; i < N; i++) begin
      bike_x[i*W +: W]   = x_q[i];
      bike_y[i*W +: W]   = y_q[i];
      bike_dir[2*i +: 2] = dir_q[i];
    end
  end

  assign alive        = alive_q;
  assign state        = state_q;
  assign winner_valid = win_v_q;
  assign winner_id    = win_id_q;

endmodule

// File: tb/tb_tron_arena_n.sv
// tb_tron_arena_n: directed scoreboard bench for tron_arena_n. Stimulus
// pushes the expected post-move snapshot for every frame; a monitor pops
// and compares one snapshot per move_tick seen on the FRAMES_PER_MOVE=1
// instance. A second instance with FRAMES_PER_MOVE=4 checks move pacing.
module tb_tron_arena_n;

  localparam int unsigned N = 2;
  localparam int unsigned W = 10;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           frame_clk = 1'b0;
  logic           start = 1'b0;
  logic           start4 = 1'b0;
  logic [N*W-1:0] spawn_x = '0;
  logic [N*W-1:0] spawn_y = '0;
  logic [2*N-1:0] spawn_dir = '0;
  logic [2*N-1:0] dir_req = '0;
  logic [N-1:0]   dir_req_valid = '0;

  logic [N*W-1:0] bike_x, bike_y;
  logic [2*N-1:0] bike_dir;
  logic [N-1:0]   alive;
  logic [1:0]     state;
  logic           move_tick, winner_valid;
  logic [2:0]     winner_id;

  logic [N*W-1:0] bike_x4, bike_y4;
  logic [2*N-1:0] bike_dir4;
  logic [N-1:0]   alive4;
  logic [1:0]     state4;
  logic           move_tick4, winner_valid4;
  logic [2:0]     winner_id4;

  tron_arena_n #(.NUM_BIKES(N), .COORD_W(W), .FRAMES_PER_MOVE(1)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .bike_x(bike_x), .bike_y(bike_y), .bike_dir(bike_dir), .alive(alive),
    .state(state), .move_tick(move_tick), .winner_valid(winner_valid),
    .winner_id(winner_id)
  );

  tron_arena_n #(.NUM_BIKES(N), .COORD_W(W), .FRAMES_PER_MOVE(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start4),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .bike_x(bike_x4), .bike_y(bike_y4), .bike_dir(bike_dir4), .alive(alive4),
    .state(state4), .move_tick(move_tick4), .winner_valid(winner_valid4),
    .winner_id(winner_id4)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [51:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   mt4_cnt = 0;

  // Snapshot layout: {x0,y0,x1,y1,dir0,dir1,alive,state,winner_valid,winner_id}
  function automatic logic [51:0] mk(int x0, int y0, int d0, int x1, int y1,
                                     int d1, int al, int st, int wv, int wid);
    return {10'(x0), 10'(y0), 10'(x1), 10'(y1), 2'(d0), 2'(d1), 2'(al),
            2'(st), 1'(wv), 3'(wid)};
  endfunction

  function automatic logic [51:0] snap();
    return {bike_x[9:0], bike_y[9:0], bike_x[19:10], bike_y[19:10],
            bike_dir[1:0], bike_dir[3:2], alive, state, winner_valid, winner_id};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic push_exp(input string name, input logic [51:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    q.push_back(e);
  endtask

  // Monitor: one expected snapshot per move_tick, compared after the update edge
  initial begin
    exp_t e;
    logic [51:0] a;
    forever begin
      @(negedge Clk);
      if (move_tick === 1'b1) begin
        @(posedge Clk);
        #1;
        a = snap();
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_move actual=%0h required=none", a);
        end else begin
          e = q.pop_front();
          if (a === e.v) passed++;
          else $display("FAIL %s actual=%0h required=%0h", e.name, a, e.v);
        end
      end
    end
  end

  always @(negedge Clk) if (move_tick4 === 1'b1) mt4_cnt++;

  task automatic frame();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic set_spawn(input int x0, input int y0, input int d0,
                           input int x1, input int y1, input int d1);
    spawn_x   = {10'(x1), 10'(x0)};
    spawn_y   = {10'(y1), 10'(y0)};
    spawn_dir = {2'(d1), 2'(d0)};
  endtask

  task automatic pulse_start();
    @(negedge Clk) start = 1'b1;
    @(negedge Clk) start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge Clk);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base;
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_x", 64'(bike_x), 64'd0);
    chk("rst_y", 64'(bike_y), 64'd0);
    chk("rst_dir_alive", 64'({bike_dir, alive}), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_move_win", 64'({move_tick, winner_valid, winner_id}), 64'd0);
    @(negedge Clk) Reset = 1'b0;

    // Straight run for 10 frames, with a start attempt mid-round that must be ignored
    set_spawn(76, 240, 3, 400, 240, 2);
    pulse_start();
    chk("start_state", 64'(state), 64'd1);
    chk("start_x", 64'(bike_x), 64'({10'd400, 10'd76}));
    chk("start_dir_alive", 64'({bike_dir, alive}), 64'({4'b1011, 2'b11}));
    for (int k = 1; k <= 5; k++) begin
      push_exp($sformatf("run_f%0d", k), mk(76 + k, 240, 3, 400 - k, 240, 2, 3, 1, 0, 0));
      frame();
    end
    set_spawn(10, 10, 0, 20, 20, 0);
    pulse_start();
    for (int k = 6; k <= 10; k++) begin
      push_exp($sformatf("run_f%0d", k), mk(76 + k, 240, 3, 400 - k, 240, 2, 3, 1, 0, 0));
      frame();
    end
    drain("run_drain");

    // Reverse request ignored for bike0, legal turn up for bike1
    @(negedge Clk);
    dir_req       = {2'd0, 2'd2};
    dir_req_valid = 2'b11;
    @(negedge Clk) dir_req_valid = 2'b00;
    push_exp("turn_f1", mk(87, 240, 3, 390, 239, 0, 3, 1, 0, 0));
    frame();
    push_exp("turn_f2", mk(88, 240, 3, 390, 238, 0, 3, 1, 0, 0));
    frame();
    drain("turn_drain");

    // Wall hit at the right boundary
    do_reset();
    set_spawn(462, 240, 3, 200, 100, 1);
    pulse_start();
    push_exp("wall", mk(462, 240, 3, 200, 101, 1, 2, 2, 1, 1));
    frame();
    drain("wall_drain");

    // Head-on collision into the same cell, restarted from OVER
    set_spawn(100, 240, 3, 102, 240, 2);
    pulse_start();
    push_exp("head_on", mk(100, 240, 3, 102, 240, 2, 0, 2, 0, 0));
    frame();
    drain("head_drain");

    // Swap collision
    set_spawn(100, 240, 3, 101, 240, 2);
    pulse_start();
    push_exp("swap", mk(100, 240, 3, 101, 240, 2, 0, 2, 0, 0));
    frame();
    drain("swap_drain");

    // Reset landing on the move edge aborts the move
    set_spawn(76, 240, 3, 400, 240, 2);
    pulse_start();
    push_exp("pre_abort", mk(77, 240, 3, 399, 240, 2, 3, 1, 0, 0));
    frame();
    drain("pre_abort_drain");
    push_exp("abort", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("abort_move_tick", 64'(move_tick), 64'd0);
    chk("abort_state", 64'(state), 64'd0);
    @(negedge Clk);
    Reset     = 1'b0;
    frame_clk = 1'b0;
    drain("abort_drain");

    // FRAMES_PER_MOVE=4: 8 frames give two moves
    do_reset();
    base = mt4_cnt;
    @(negedge Clk) start4 = 1'b1;
    @(negedge Clk) start4 = 1'b0;
    repeat (8) frame();
    chk("fpm4_pulses", 64'(mt4_cnt - base), 64'd2);
    chk("fpm4_x", 64'(bike_x4), 64'({10'd398, 10'd78}));
    chk("fpm4_state", 64'(state4), 64'd1);
    chk("fpm4_idle_other", 64'(state), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tron_arena_n.md
TRON_ARENA_N -- requirements
Module: tron_arena_n

Interface
REQ-001 The module SHALL expose the following parameters (name, default, meaning), one per line:
- NUM_BIKES, 2, number of bikes (2..8).
- COORD_W, 10, coordinate width in bits.
- X_MIN, 14, leftmost legal X.
- X_MAX, 462, rightmost legal X.
- Y_MIN, 14, topmost legal Y.
- Y_MAX, 462, bottommost legal Y.
- STEP, 1, pixels moved per move tick.
- FRAMES_PER_MOVE, 1, frame ticks per move (1..255).
REQ-002 The module SHALL have the following ports (name, direction, width, meaning), one per line; N = NUM_BIKES, W = COORD_W; bike i occupies slice i of every packed vector.
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous active-high reset.
- frame_clk, in, 1, frame strobe (~60 Hz), asynchronous to Clk phase.
- start, in, 1, one-cycle request to load spawns and begin a round.
- spawn_x / spawn_y, in, N*W, spawn coordinates, sampled on an accepted start.
- spawn_dir, in, 2*N, spawn directions, sampled on an accepted start.
- dir_req, in, 2*N, requested direction per bike.
- dir_req_valid, in, N, qualifies dir_req per bike.
- bike_x / bike_y, out, N*W, current positions.
- bike_dir, out, 2*N, current directions.
- alive, out, N, per-bike alive flag.
- state, out, 2, 0 IDLE, 1 RUN, 2 OVER.
- move_tick, out, 1, one-cycle pulse in the cycle that moves are applied.
- winner_valid, out, 1, high in OVER when exactly one bike survives.
- winner_id, out, 3, index of the surviving bike.
REQ-003 Reset SHALL be Reset, synchronous, active-high; the clock SHALL be Clk.
REQ-004 Directions SHALL be encoded as 0 up (Y-STEP), 1 down (Y+STEP), 2 left (X-STEP), 3 right (X+STEP).

Function
REQ-005 frame_clk SHALL be registered once; an internal tick SHALL be registered high for one cycle when frame_clk is sampled 1 and the delayed copy is 0.
REQ-006 A frame counter SHALL count ticks from 0 to FRAMES_PER_MOVE-1 in RUN; move_tick SHALL assert on the tick that wraps the counter to 0.
REQ-007 The frame counter SHALL be held at 0 outside RUN.
REQ-008 State register updates SHALL occur on the Clk edge that ends the move_tick cycle, i.e. 2 Clk edges after frame_clk is first sampled high when FRAMES_PER_MOVE=1.
REQ-009 Each bike SHALL hold a pending direction register, overwritten in any cycle its dir_req_valid is 1; the latest request before move_tick wins.
REQ-010 At move_tick, a pending direction that is the reverse of the current direction (up/down, left/right) SHALL be discarded; otherwise it becomes bike_dir.
REQ-011 Pending directions SHALL be cleared to the current direction after each move_tick.
REQ-012 Next position SHALL be computed from the direction selected at that move_tick, in W-bit unsigned arithmetic.
REQ-013 A wall hit SHALL be detected before subtraction, with no reliance on wraparound, by any of these checks:
- up with Y < Y_MIN+STEP;
- down with Y+STEP > Y_MAX;
- left with X < X_MIN+STEP;
- right with X+STEP > X_MAX.
REQ-014 A head collision SHALL occur when two alive bikes have equal next positions, or when each bike's next position equals the other's current position (swap); all bikes involved SHALL die.
REQ-015 A dying bike SHALL keep its pre-move position, clear alive, and never move again in the round; dead bikes SHALL be excluded from head checks.
REQ-016 An alive, non-colliding bike SHALL take its next position at the move_tick update edge.
REQ-017 State transitions SHALL be:
- IDLE to RUN on start;
- RUN to OVER at the update edge where alive count after the move is <= 1;
- OVER to RUN on start.
REQ-018 start SHALL be ignored in RUN.
REQ-019 On an accepted start, positions, directions and pending directions SHALL load from the spawn inputs, all alive bits SHALL be set, and the frame counter SHALL clear.
REQ-020 In OVER with exactly one survivor, winner_valid SHALL be 1 and winner_id SHALL be that bike's index; with zero survivors (draw), winner_valid SHALL be 0 and winner_id SHALL be 0.
REQ-021 A tick coinciding with an accepted start SHALL be ignored.

Reset
REQ-022 When Reset is high, all outputs and internal registers SHALL be set to 0 and state SHALL be IDLE.
REQ-023 Reset SHALL take priority over start and tick in the same cycle.
REQ-024 Reset asserted mid-round SHALL abort the round with no move applied.

Verification
REQ-025 The bench SHALL cover these scenarios, one line each:
- Spawn (76,240,right) and (400,240,left), FRAMES_PER_MOVE=1, 10 frames -> bike0 X=86, bike1 X=390, both alive, state RUN.
- bike0 dir right, dir_req=left valid, one frame -> request ignored, X increments by 1, bike_dir stays 3.
- Spawn bike0 at X=462 moving right, one frame -> alive[0]=0, X stays 462, state OVER, winner_valid=1, winner_id=1.
- Bikes at (100,240,right) and (102,240,left), one frame -> both next X=101, both die, state OVER, winner_valid=0.
- FRAMES_PER_MOVE=4, 8 frames -> exactly 2 move_tick pulses, position advanced by 2.
- Reset asserted mid-RUN coinciding with a tick -> next cycle all outputs 0, state IDLE, no move applied.
